// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and default operand width for serial_adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit per clock; SERIAL_ADDER_SUB_EN adds a subtract port
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_b_ld;
  logic             w_c_ld;
  logic             w_s;
  logic             w_co;
  logic             w_go;
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_ld = sub ? ~b : b;
  assign w_c_ld = sub | c_in;
`else
  assign w_b_ld = b;
  assign w_c_ld = c_in;
`endif
  assign w_go = start && (r_state != SHIFT);
  assign busy = r_state == SHIFT;
  assign done = r_state == DONE;
  full_adder u_fa (
    .i_a(r_a[0]),
    .i_b(r_b[0]),
    .i_c(r_carry),
    .o_s(w_s),
    .o_c(w_co)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (w_go) begin
      r_state <= SHIFT;
      r_a     <= a;
      r_b     <= w_b_ld;
      r_carry <= w_c_ld;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_co;
      r_res   <= {w_s, r_res[WIDTH-1:1]};
      r_cnt   <= r_cnt + CW'(1);
      if (r_cnt == CW'(WIDTH-1)) begin
        r_state  <= DONE;
        sum      <= {w_s, r_res[WIDTH-1:1]};
        c_out    <= w_co;
        overflow <= r_carry ^ w_co;
      end
    end else
      r_state <= IDLE;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       c_in = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       c_out;
  logic       overflow;
  int         checks = 0;
  int         errors = 0;
  serial_adder #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .a(a),
    .b(b),
    .c_in(c_in),
    .busy(busy),
    .done(done),
    .sum(sum),
    .c_out(c_out),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done, sum, c_out, overflow} !== 12'h0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b sum=%h c=%b v=%b, want all 0", busy, done, sum, c_out, overflow);
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic run_op(input string nm, input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic is, input logic [7:0] es, input logic ec, input logic ev);
    a = ia;
    b = ib;
    c_in = ic;
    sub = is;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 8; i++) begin
      checks++;
      if ({busy, done} !== 2'b10) begin
        errors++;
        $display("FAIL %s shift cycle %0d: got busy=%b done=%b, want busy=1 done=0", nm, i, busy, done);
      end
      tick();
    end
    tick();
    checks++;
    if ({busy, done, sum, c_out, overflow} !== {2'b01, es, ec, ev}) begin
      errors++;
      $display("FAIL %s result: got busy=%b done=%b sum=%h c=%b v=%b, want busy=0 done=1 sum=%h c=%b v=%b",
               nm, busy, done, sum, c_out, overflow, es, ec, ev);
    end
    tick();
    checks++;
    if ({busy, done, sum, c_out, overflow} !== {2'b00, es, ec, ev}) begin
      errors++;
      $display("FAIL %s hold: got busy=%b done=%b sum=%h c=%b v=%b, want idle with sum=%h c=%b v=%b",
               nm, busy, done, sum, c_out, overflow, es, ec, ev);
    end
  endtask
  task automatic test_add();
    run_op("add_05_03", 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("add_a5_5a_ci", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask
  task automatic test_ignore_start();
    a = 8'h05;
    b = 8'h03;
    c_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hFF;
    b = 8'hFF;
    c_in = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 4; i < 8; i++) tick();
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL ignore timing: got busy=%b done=%b at 7th shift edge, want busy=1 done=0", busy, done);
    end
    tick();
    checks++;
    if ({done, sum, c_out, overflow} !== {1'b1, 8'h08, 2'b00}) begin
      errors++;
      $display("FAIL ignore result: got done=%b sum=%h c=%b v=%b, want done=1 sum=08 c=0 v=0", done, sum, c_out, overflow);
    end
    tick();
  endtask
  task automatic test_back_to_back();
    a = 8'h10;
    b = 8'h20;
    c_in = 1'b1;
    start = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i < 8; i++) begin
        checks++;
        if ({busy, done} !== 2'b10) begin
          errors++;
          $display("FAIL b2b op %0d cycle %0d: got busy=%b done=%b, want busy=1 done=0", r, i, busy, done);
        end
        tick();
      end
      tick();
      checks++;
      if ({busy, done, sum, c_out, overflow} !== {2'b01, 8'h31, 2'b00}) begin
        errors++;
        $display("FAIL b2b op %0d result: got busy=%b done=%b sum=%h c=%b v=%b, want done=1 sum=31 c=0 v=0",
                 r, busy, done, sum, c_out, overflow);
      end
      tick();
      checks++;
      if ({busy, done} !== 2'b10) begin
        errors++;
        $display("FAIL b2b op %0d restart: got busy=%b done=%b, want busy=1 done=0", r, busy, done);
      end
    end
    start = 1'b0;
    repeat (9) tick();
  endtask
  task automatic test_abort();
    int pulses = 0;
    a = 8'h7F;
    b = 8'h01;
    c_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, sum, c_out, overflow} !== 12'h0) begin
      errors++;
      $display("FAIL abort clear: got busy=%b done=%b sum=%h c=%b v=%b, want all 0", busy, done, sum, c_out, overflow);
    end
    for (int i = 0; i < 10; i++) begin
      if (done) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort no_done: got %0d done pulses, want 0", pulses);
    end
    run_op("after_abort", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask
`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
  endtask
`endif
  initial begin
    test_reset();
    test_add();
    test_ignore_start();
    test_back_to_back();
    test_abort();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition on the current a, b and c_in.
REQ-005 The block SHALL have ports a and b, inputs, WIDTH bits each: operands, sampled only on an accepted start.
REQ-006 The block SHALL have port c_in, input, 1 bit: carry-in, sampled only on an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result becomes valid.
REQ-009 The block SHALL have port sum, output, WIDTH bits: result, held stable from done until the next accepted start.
REQ-010 The block SHALL have port c_out, output, 1 bit: final carry-out, held like sum.
REQ-011 The block SHALL have port overflow, output, 1 bit: two's-complement overflow flag, held like sum.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE; in SHIFT it is ignored, with no effect on the operation in progress.
REQ-014 On an accepted start at edge k: load a, b into shift registers, load c_in into the carry flop, clear the bit counter, enter SHIFT.
REQ-015 In SHIFT, each edge SHALL add the LSB of each operand register and the carry flop using one full adder; shift the sum bit into the MSB of the result register; shift the operands right; update the carry flop.
REQ-016 After exactly WIDTH SHIFT edges (edge k+WIDTH), the FSM SHALL enter DONE.
REQ-017 done SHALL be high only in DONE, for exactly one cycle; edge k+WIDTH+1 SHALL return the FSM to IDLE unless a new start is accepted.
REQ-018 busy SHALL be high exactly in SHIFT.
REQ-019 Results:
- sum = (a + b + c_in) mod 2^WIDTH
- c_out = bit WIDTH of the full-width sum
- overflow = carry into the MSB XOR c_out
REQ-020 sum, c_out and overflow SHALL be updated only at the transition into DONE; intermediate shifting SHALL NOT appear on these ports.
REQ-021 A start accepted in DONE SHALL begin a new operation back-to-back; done still pulses for the finished result.

Reset
REQ-022 rst high at a rising edge SHALL force IDLE and clear busy, done, sum, c_out, overflow, the carry flop and the counter to 0.
REQ-023 rst SHALL take priority over start and SHALL abort an operation mid-SHIFT with no done pulse.

Configuration
REQ-024 With macro SERIAL_ADDER_SUB_EN defined, the block SHALL add input port sub (1 bit, sampled on accepted start).
- When sub=1, the operation SHALL be a - b: load ~b and force the carry-in to 1, ignoring c_in.
- overflow SHALL keep the definition of REQ-019.
REQ-025 Without SERIAL_ADDER_SUB_EN, port sub SHALL NOT exist and the block SHALL always add.

Structure
REQ-026 Package serial_adder_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-027 The per-bit sum SHALL use one instance of the team's existing full_adder sub-module; no other sub-module.

Verification
REQ-028 WIDTH=8, a=0x05, b=0x03, c_in=0, start at edge k -> busy for edges k+1..k+8, done in cycle after edge k+8; sum=0x08, c_out=0, overflow=0.
REQ-029 a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, overflow=0; a=0x7F, b=0x01 -> sum=0x80, c_out=0, overflow=1.
REQ-030 start pulsed again mid-SHIFT with different operands -> ignored; original result and timing unchanged.
REQ-031 rst asserted on the 4th SHIFT cycle -> next cycle IDLE, all outputs 0, no done pulse; a following start completes normally.
REQ-032 start held high continuously with a=0x10, b=0x20, c_in=1 -> done every WIDTH+1 cycles, sum=0x31 each time.
REQ-033 With SERIAL_ADDER_SUB_EN, sub=1, a=0x05, b=0x07 -> sum=0xFE, c_out=0; a=0x80, b=0x01 -> sum=0x7F, overflow=1.
